// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: decides BRCC/BRCS/BREQ/BRN/BRNE/CALL/RET-family outcomes,
// maintains a circular return-address stack, and flags mispredictions with a corrected PC.
module branch_resolve_unit #(
  parameter  int ADDR_W    = 10,
  parameter  int RAS_DEPTH = 8,
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              valid,
  input  logic [3:0]        branch_type,
  input  logic              c,
  input  logic              z,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] target,
  input  logic              pred_taken,
  output logic              br_taken,
  output logic              flush,
  output logic [ADDR_W-1:0] next_pc,
  output logic              int_en_set,
  output logic              int_en_clr,
  output logic [CNT_W-1:0]  ras_count,
  output logic              ras_ovf,
  output logic              ras_unf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic [3:0] {
    BT_NONE  = 4'h0,
    BT_BRCC  = 4'h1,
    BT_BRCS  = 4'h2,
    BT_BREQ  = 4'h3,
    BT_BRN   = 4'h4,
    BT_BRNE  = 4'h5,
    BT_CALL  = 4'h6,
    BT_RET   = 4'h7,
    BT_RETID = 4'h8,
    BT_RETIE = 4'h9
  } br_type_e;

  typedef enum logic {RUN, SHADOW} state_e;

  state_e state, state_nxt;

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr;   // next slot to write; top of stack is ras_ptr-1
  logic [CNT_W-1:0]  ras_cnt;

  logic              taken, is_call, is_ret;
  logic              act, mispredict;
  logic              ras_empty, ras_full;
  logic [ADDR_W-1:0] pc_inc, ras_top, sel_target, resolved_pc;

  // Instruction decode
  always_comb begin
    taken   = 1'b0;
    is_call = 1'b0;
    is_ret  = 1'b0;
    case (branch_type)
      BT_BRCC:                      taken = ~c;
      BT_BRCS:                      taken = c;
      BT_BREQ:                      taken = z;
      BT_BRNE:                      taken = ~z;
      BT_BRN:                       taken = 1'b1;
      BT_CALL:  begin taken = 1'b1; is_call = 1'b1; end
      BT_RET, BT_RETID, BT_RETIE:
                begin taken = 1'b1; is_ret  = 1'b1; end
      default:                      taken = 1'b0;
    endcase
  end

  assign pc_inc    = pc + ADDR_W'(1);
  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_mem[ras_ptr - PTR_W'(1)];
  assign ras_count = ras_cnt;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    else     state <= state_nxt;
  end

  // FSM next state: the slot after a flush is on the wrong path and is discarded
  always_comb begin
    state_nxt = state;
    if (!stall) begin
      case (state)
        RUN:     state_nxt = mispredict ? SHADOW : RUN;
        SHADOW:  state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  // FSM outputs: effective-instruction qualification and resolution
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    act         = valid & ~stall & (state == RUN);
    mispredict  = act & (taken != pred_taken);
    sel_target  = target;
    if (is_ret) sel_target = ras_empty ? '0 : ras_top;
    resolved_pc = taken ? sel_target : pc_inc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_taken   <= 1'b0;
      flush      <= 1'b0;
      next_pc    <= '0;
      int_en_set <= 1'b0;
      int_en_clr <= 1'b0;
    end else if (!stall) begin
      br_taken   <= act & taken;
      flush      <= mispredict;
      int_en_set <= act & (branch_type == BT_RETIE);
      int_en_clr <= act & (branch_type == BT_RETID);
      if (act) next_pc <= resolved_pc;
    end
  end

  // Stack bookkeeping; a push while full wraps onto the oldest entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_ptr <= '0;
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (act) begin
      if (is_call) begin
        ras_ptr <= ras_ptr + PTR_W'(1);
        if (ras_full) ras_ovf <= 1'b1;
        else          ras_cnt <= ras_cnt + CNT_W'(1);
      end else if (is_ret) begin
        if (ras_empty) begin
          ras_unf <= 1'b1;
        end else begin
          ras_ptr <= ras_ptr - PTR_W'(1);
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the stack storage is left unreset; pointer and count fully define which entries are live.
  always_ff @(posedge clk) begin
    if (act && is_call) ras_mem[ras_ptr] <= pc_inc;
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed corner cases followed by random
// traffic, all compared against a queue-based behavioural model.
module tb_branch_resolve_unit;

  localparam int ADDR_W    = 10;
  localparam int RAS_DEPTH = 8;
  localparam int CNT_W     = $clog2(RAS_DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              stall, valid, c, z, pred_taken;
  logic [3:0]        branch_type;
  logic [ADDR_W-1:0] pc, target;
  logic              br_taken, flush, int_en_set, int_en_clr, ras_ovf, ras_unf;
  logic [ADDR_W-1:0] next_pc;
  logic [CNT_W-1:0]  ras_count;

  int tests_run = 0;
  int tests_failed = 0;

  branch_resolve_unit #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .valid(valid), .branch_type(branch_type),
    .c(c), .z(z), .pc(pc), .target(target), .pred_taken(pred_taken),
    .br_taken(br_taken), .flush(flush), .next_pc(next_pc),
    .int_en_set(int_en_set), .int_en_clr(int_en_clr),
    .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  always #5 clk = ~clk;

  // Behavioural reference: stack as a queue (back = newest), wrong-path slot as a flag
  logic [ADDR_W-1:0] m_ras[$];
  bit                m_shadow;
  bit                e_br, e_flush, e_set, e_clr, e_ovf, e_unf;
  logic [ADDR_W-1:0] e_npc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ras.delete();
    m_shadow = 1'b0;
    e_br = 0; e_flush = 0; e_set = 0; e_clr = 0; e_ovf = 0; e_unf = 0;
    e_npc = '0;
  endtask

  task automatic model_step();
    bit                act, tk;
    logic [ADDR_W-1:0] pc1, t;
    if (stall) return;
    act = valid && !m_shadow;
    case (branch_type)
      4'd1: tk = !c;
      4'd2: tk = c;
      4'd3: tk = z;
      4'd5: tk = !z;
      4'd4, 4'd6, 4'd7, 4'd8, 4'd9: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    e_br    = act && tk;
    e_flush = act && (tk != pred_taken);
    e_set   = act && branch_type == 4'd9;
    e_clr   = act && branch_type == 4'd8;
    if (act) begin
      pc1 = ADDR_W'((int'(pc) + 1) % (1 << ADDR_W));
      t   = target;
      if (branch_type == 4'd6) begin
        if (m_ras.size() == RAS_DEPTH) begin
          void'(m_ras.pop_front());
          e_ovf = 1'b1;
        end
        m_ras.push_back(pc1);
      end else if (branch_type >= 4'd7 && branch_type <= 4'd9) begin
        if (m_ras.size() == 0) begin
          t     = '0;
          e_unf = 1'b1;
        end else begin
          t = m_ras.pop_back();
        end
      end
      e_npc = tk ? t : pc1;
    end
    m_shadow = e_flush;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".br_taken"},   32'(br_taken),   32'(e_br));
    check({tag, ".flush"},      32'(flush),      32'(e_flush));
    check({tag, ".int_en_set"}, 32'(int_en_set), 32'(e_set));
    check({tag, ".int_en_clr"}, 32'(int_en_clr), 32'(e_clr));
    check({tag, ".ras_count"},  32'(ras_count),  32'(m_ras.size()));
    check({tag, ".ras_ovf"},    32'(ras_ovf),    32'(e_ovf));
    check({tag, ".ras_unf"},    32'(ras_unf),    32'(e_unf));
    if (e_flush) check({tag, ".next_pc"}, 32'(next_pc), 32'(e_npc));
  endtask

  // Apply one cycle of inputs at the falling edge, then compare at the next falling edge
  task automatic step(input string tag, input logic s, input logic v, input logic [3:0] bt,
                      input logic cc, input logic zz, input logic [ADDR_W-1:0] p,
                      input logic [ADDR_W-1:0] t, input logic pr);
    stall = s; valid = v; branch_type = bt; c = cc; z = zz; pc = p; target = t; pred_taken = pr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; valid = 1'b0; branch_type = '0; c = 1'b0; z = 1'b0;
    pc = '0; target = '0; pred_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    check("reset.next_pc", 32'(next_pc), 32'h0);
    rst = 1'b0;

    // BREQ taken but predicted not-taken, then the wrong-path slot must be ignored
    step("breq", 0, 1, 4'd3, 0, 1, 10'h010, 10'h080, 0);
    check("breq.npc_const", 32'(next_pc), 32'h080);
    check("breq.flush_const", 32'(flush), 32'h1);
    step("shadow", 0, 1, 4'd4, 0, 0, 10'h011, 10'h200, 0);
    check("shadow.flush_const", 32'(flush), 32'h0);
    check("shadow.br_const", 32'(br_taken), 32'h0);

    // BRCC not taken at the top of the address space wraps PC+1 to zero
    step("brcc_wrap", 0, 1, 4'd1, 1, 0, 10'h3FF, 10'h123, 1);
    check("brcc_wrap.npc_const", 32'(next_pc), 32'h000);
    check("brcc_wrap.br_const", 32'(br_taken), 32'h0);
    idle("brcc_wrap.shadow");

    // CALL then RETIE returning to the call's successor
    step("call", 0, 1, 4'd6, 0, 0, 10'h020, 10'h300, 1);
    check("call.count_const", 32'(ras_count), 32'h1);
    step("retie", 0, 1, 4'd9, 0, 0, 10'h301, 10'h000, 0);
    check("retie.npc_const", 32'(next_pc), 32'h021);
    check("retie.set_const", 32'(int_en_set), 32'h1);
    check("retie.count_const", 32'(ras_count), 32'h0);
    idle("retie.after");
    check("retie.set_pulse_end", 32'(int_en_set), 32'h0);

    // Overflow: nine calls, then eight returns in LIFO order
    for (int i = 0; i < 9; i++)
      step("ovf_call", 0, 1, 4'd6, 0, 0, ADDR_W'(10'h100 + i), 10'h040, 1);
    check("ovf.flag_const", 32'(ras_ovf), 32'h1);
    check("ovf.count_const", 32'(ras_count), 32'h8);
    for (int i = 0; i < 8; i++) begin
      step("ovf_ret", 0, 1, 4'd7, 0, 0, 10'h040, 10'h000, 0);
      check("ovf_ret.npc_const", 32'(next_pc), 32'(10'h109 - i));
      idle("ovf_ret.shadow");
    end
    check("ovf_ret.count_const", 32'(ras_count), 32'h0);

    // Underflow: return with an empty stack
    step("unf", 0, 1, 4'd7, 0, 0, 10'h055, 10'h0AA, 0);
    check("unf.flag_const", 32'(ras_unf), 32'h1);
    check("unf.npc_const", 32'(next_pc), 32'h000);
    idle("unf.shadow");
    idle("unf.idle");
    check("unf.sticky_const", 32'(ras_unf), 32'h1);

    // Stall holds a flush pulse; async reset mid-stall clears without a clock edge
    step("stall_br", 0, 1, 4'd3, 0, 1, 10'h050, 10'h0AA, 0);
    for (int i = 0; i < 3; i++) begin
      step("stall_hold", 1, 1, 4'd4, 0, 0, 10'h051, 10'h111, 0);
      check("stall_hold.flush_const", 32'(flush), 32'h1);
      check("stall_hold.npc_const", 32'(next_pc), 32'h0AA);
    end
    rst = 1'b1;
    #2;
    model_reset();
    check("async_rst.flush", 32'(flush), 32'h0);
    check("async_rst.npc", 32'(next_pc), 32'h0);
    check("async_rst.count", 32'(ras_count), 32'h0);
    check("async_rst.unf", 32'(ras_unf), 32'h0);
    compare_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;

    // Random traffic biased toward calls/returns so the stack fills and drains
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] bt;
      int         r;
      r  = int'($urandom_range(0, 99));
      bt = (r < 25) ? 4'd6 : (r < 50) ? 4'(7 + $urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) != 0), bt,
           1'($urandom), 1'($urandom), ADDR_W'($urandom), ADDR_W'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
